// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: single-clock FIFO with standard or first-word-fall-through
// read mode, programmable thresholds, occupancy, overflow/underflow pulses
// and a synchronous flush. In FWFT mode the words held in the prefetch stage
// and in the output register count towards FIFO_DEPTH.
module sync_fifo_prog #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 32,
    parameter bit FWFT       = 1'b0,
    parameter     RAM_TYPE   = "block",
    localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  i_clk,
    input  logic                  i_s_rst,
    input  logic                  i_flush,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_valid,
    input  logic [CW-1:0]         i_prog_full_thresh,
    input  logic [CW-1:0]         i_prog_empty_thresh,
    output logic                  o_full,
    output logic                  o_almost_full,
    output logic                  o_prog_full,
    output logic                  o_empty,
    output logic                  o_almost_empty,
    output logic                  o_prog_empty,
    output logic [CW-1:0]         o_count,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] DEPTH_M1_C = CW'(FIFO_DEPTH - 1);

    (* ram_style = RAM_TYPE *) logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  rd_valid_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  readable;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  mem_rd;

    assign o_count        = count;
    assign o_rd_valid     = rd_valid_q;
    assign o_rd_data      = rd_data_q;
    assign o_overflow     = overflow_q;
    assign o_underflow    = underflow_q;
    assign o_full         = (count == DEPTH_C);
    assign o_almost_full  = (count == DEPTH_M1_C);
    assign o_almost_empty = (count == CW'(1));
    assign o_prog_full    = (count >= i_prog_full_thresh);
    assign o_prog_empty   = (count <= i_prog_empty_thresh);
    assign o_empty        = FWFT ? !rd_valid_q : (count == '0);

    // In FWFT mode only a presented word can be popped; otherwise any stored word.
    assign readable = FWFT ? rd_valid_q : (count != '0);
    assign wr_acc   = i_wr_en && !o_full;
    assign rd_acc   = i_rd_en && readable;

    // Storage write port, left without reset so it maps onto RAM.
    always_ff @(posedge i_clk) begin
        if (wr_acc && !i_s_rst && !i_flush) begin
            mem[wr_ptr] <= i_wr_data;
        end
    end

    // Pointers, occupancy and rejection pulses.
    always_ff @(posedge i_clk) begin
        if (i_s_rst || i_flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (mem_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            overflow_q  <= i_wr_en && !wr_acc;
            underflow_q <= i_rd_en && !rd_acc;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            // RAM -> prefetch (mid) -> output register; the prefetch stage
            // keeps the output fed under back-to-back pops.
            logic                  mid_valid;
            logic [DATA_WIDTH-1:0] mid_data;
            logic                  out_free;
            logic                  mid_free;
            logic [CW-1:0]         mem_cnt;

            assign out_free = !rd_valid_q || rd_acc;
            assign mid_free = !mid_valid || out_free;
            assign mem_cnt  = count - CW'(rd_valid_q) - CW'(mid_valid);
            assign mem_rd   = mid_free && (mem_cnt != '0);

            // Advance the prefetch and output stages.
            always_ff @(posedge i_clk) begin
                if (i_s_rst) begin
                    rd_valid_q <= 1'b0;
                    rd_data_q  <= '0;
                    mid_valid  <= 1'b0;
                    mid_data   <= '0;
                end else if (i_flush) begin
                    rd_valid_q <= 1'b0;
                    mid_valid  <= 1'b0;
                end else begin
                    if (out_free) begin
                        rd_valid_q <= mid_valid;
                        if (mid_valid) rd_data_q <= mid_data;
                    end
                    if (mid_free) begin
                        mid_valid <= mem_rd;
                        if (mem_rd) mid_data <= mem[rd_ptr];
                    end
                end
            end
        end else begin : g_std
            assign mem_rd = rd_acc;

            // Registered read: data and valid one cycle after the accepted request.
            always_ff @(posedge i_clk) begin
                if (i_s_rst) begin
                    rd_valid_q <= 1'b0;
                    rd_data_q  <= '0;
                end else if (i_flush) begin
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc) rd_data_q <= mem[rd_ptr];
                end
            end
        end
    endgenerate

`ifndef SYNTHESIS
    // Simulation notices for accesses that the FIFO silently drops.
    always_ff @(posedge i_clk) begin
        if (!i_s_rst && !i_flush) begin
            assert (!(i_wr_en && o_full))
                else $info("sync_fifo_prog: write while full ignored");
            assert (!(i_rd_en && !readable))
                else $info("sync_fifo_prog: read while empty ignored");
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: a standard-mode and an FWFT instance share the
// same stimulus; each is checked against a queue-based reference model.
module tb_sync_fifo_prog;

    localparam int DW = 8;
    localparam int DEPTH = 8;
    localparam int CW = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst, flush, wr_en, rd_en;
    logic [DW-1:0] wr_data;
    logic [CW-1:0] pf_th, pe_th;

    logic [DW-1:0] s_data, f_data;
    logic          s_valid, s_full, s_afull, s_pfull, s_empty, s_aempty, s_pempty, s_ovf, s_unf;
    logic          f_valid, f_full, f_afull, f_pfull, f_empty, f_aempty, f_pempty, f_ovf, f_unf;
    logic [CW-1:0] s_count, f_count;

    int npass = 0;
    int ntotal = 0;

    always #5 clk = ~clk;

    sync_fifo_prog #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FWFT(1'b0)) dut_std (
        .i_clk(clk), .i_s_rst(rst), .i_flush(flush), .i_wr_en(wr_en), .i_wr_data(wr_data),
        .i_rd_en(rd_en), .o_rd_data(s_data), .o_rd_valid(s_valid),
        .i_prog_full_thresh(pf_th), .i_prog_empty_thresh(pe_th),
        .o_full(s_full), .o_almost_full(s_afull), .o_prog_full(s_pfull), .o_empty(s_empty),
        .o_almost_empty(s_aempty), .o_prog_empty(s_pempty), .o_count(s_count),
        .o_overflow(s_ovf), .o_underflow(s_unf));

    sync_fifo_prog #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FWFT(1'b1)) dut_fw (
        .i_clk(clk), .i_s_rst(rst), .i_flush(flush), .i_wr_en(wr_en), .i_wr_data(wr_data),
        .i_rd_en(rd_en), .o_rd_data(f_data), .o_rd_valid(f_valid),
        .i_prog_full_thresh(pf_th), .i_prog_empty_thresh(pe_th),
        .o_full(f_full), .o_almost_full(f_afull), .o_prog_full(f_pfull), .o_empty(f_empty),
        .o_almost_empty(f_aempty), .o_prog_empty(f_pempty), .o_count(f_count),
        .o_overflow(f_ovf), .o_underflow(f_unf));

    // Reference model: contents as queues; FWFT words carry the edge index at
    // which they were written and become visible two edges later.
    logic [DW-1:0] q_s[$];
    logic [DW-1:0] q_f[$];
    int            t_f[$];
    int            e = 0;
    logic          ev_s = 1'b0;
    logic [DW-1:0] ed_s = '0, ed_f = '0;
    logic          ovf_s = 1'b0, unf_s = 1'b0, ovf_f = 1'b0, unf_f = 1'b0;

    function automatic logic fwft_visible(input int edge_now);
        if (q_f.size() == 0) return 1'b0;
        return t_f[0] <= edge_now - 2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        ntotal++;
        assert (obs === exp_v) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    endtask

    task automatic model_edge(input logic wr, input logic [DW-1:0] d, input logic rd,
                              input logic fl, input logic rs);
        logic          vis_pre, wacc, racc;
        logic [DW-1:0] tmp;
        int            tint;
        vis_pre = fwft_visible(e);
        e++;
        if (rs || fl) begin
            q_s.delete(); q_f.delete(); t_f.delete();
            ev_s = 1'b0; ovf_s = 1'b0; unf_s = 1'b0; ovf_f = 1'b0; unf_f = 1'b0;
            if (rs) begin
                ed_s = '0;
                ed_f = '0;
            end
        end else begin
            wacc  = wr && (q_s.size() < DEPTH);
            racc  = rd && (q_s.size() > 0);
            ovf_s = wr && !wacc;
            unf_s = rd && !racc;
            ev_s  = racc;
            if (racc) ed_s = q_s.pop_front();
            if (wacc) q_s.push_back(d);

            wacc  = wr && (q_f.size() < DEPTH);
            racc  = rd && vis_pre;
            ovf_f = wr && !wacc;
            unf_f = rd && !racc;
            if (racc) begin
                tmp  = q_f.pop_front();
                tint = t_f.pop_front();
            end
            if (wacc) begin
                q_f.push_back(d);
                t_f.push_back(e);
            end
        end
        if (fwft_visible(e)) ed_f = q_f[0];
    endtask

    task automatic check_all();
        int   ns, nf;
        logic vf;
        ns = q_s.size();
        nf = q_f.size();
        vf = fwft_visible(e);
        chk("s_count",  32'(s_count),  32'(ns));
        chk("s_full",   32'(s_full),   32'(ns == DEPTH));
        chk("s_afull",  32'(s_afull),  32'(ns == DEPTH - 1));
        chk("s_pfull",  32'(s_pfull),  32'(ns >= int'(pf_th)));
        chk("s_empty",  32'(s_empty),  32'(ns == 0));
        chk("s_aempty", 32'(s_aempty), 32'(ns == 1));
        chk("s_pempty", 32'(s_pempty), 32'(ns <= int'(pe_th)));
        chk("s_ovf",    32'(s_ovf),    32'(ovf_s));
        chk("s_unf",    32'(s_unf),    32'(unf_s));
        chk("s_valid",  32'(s_valid),  32'(ev_s));
        chk("s_data",   32'(s_data),   32'(ed_s));
        chk("f_count",  32'(f_count),  32'(nf));
        chk("f_full",   32'(f_full),   32'(nf == DEPTH));
        chk("f_afull",  32'(f_afull),  32'(nf == DEPTH - 1));
        chk("f_pfull",  32'(f_pfull),  32'(nf >= int'(pf_th)));
        chk("f_empty",  32'(f_empty),  32'(!vf));
        chk("f_aempty", 32'(f_aempty), 32'(nf == 1));
        chk("f_pempty", 32'(f_pempty), 32'(nf <= int'(pe_th)));
        chk("f_ovf",    32'(f_ovf),    32'(ovf_f));
        chk("f_unf",    32'(f_unf),    32'(unf_f));
        chk("f_valid",  32'(f_valid),  32'(vf));
        chk("f_data",   32'(f_data),   32'(ed_f));
    endtask

    task automatic step(input logic wr, input logic [DW-1:0] d, input logic rd,
                        input logic fl, input logic rs);
        wr_en   = wr;
        wr_data = d;
        rd_en   = rd;
        flush   = fl;
        rst     = rs;
        @(posedge clk);
        model_edge(wr, d, rd, fl, rs);
        #1;
        check_all();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        pf_th = CW'(5); pe_th = CW'(2);

        // Reset state
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 1);

        // Fill to full, overflow attempt, idle, drain in order
        for (int i = 1; i <= 8; i++) step(1, 8'(i), 0, 0, 0);
        step(1, 8'h09, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 0, 0, 0);

        // Steady count 3 with simultaneous read+write across pointer wrap
        for (int i = 0; i < 3; i++) step(1, 8'(8'h20 + i), 0, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        for (int i = 3; i < 13; i++) step(1, 8'(8'h20 + i), 1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 0);

        // FWFT latency from empty, then back-to-back pops
        step(0, 8'h00, 0, 1, 0);
        step(1, 8'hA5, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        chk("fwft_a5_data", 32'(f_data), 32'h0000_00A5);
        for (int i = 0; i < 4; i++) step(1, 8'(8'hB0 + i), 0, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 8'h00, 1, 0, 0);

        // Programmable thresholds, live threshold change
        step(0, 8'h00, 0, 1, 0);
        for (int i = 0; i < 6; i++) step(1, 8'(8'h40 + i), 0, 0, 0);
        pf_th = CW'(7);
        #1;
        check_all();
        pf_th = CW'(5);
        #1;
        check_all();

        // Underflow while empty
        step(0, 8'h00, 0, 1, 0);
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 0, 0, 0);

        // Flush with a write, then reset with a write, each from half-full
        for (int i = 0; i < 4; i++) step(1, 8'(8'h60 + i), 0, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        step(1, 8'h55, 0, 0, 0);
        step(1, 8'h77, 0, 1, 0);
        step(0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 8'(8'h70 + i), 0, 0, 0);
        step(1, 8'h88, 0, 0, 1);
        step(0, 8'h00, 0, 0, 0);

        // Randomised traffic with occasional flush/reset and threshold changes
        for (int i = 0; i < 600; i++) begin
            if (i % 25 == 0) begin
                pf_th = CW'($urandom_range(0, 9));
                pe_th = CW'($urandom_range(0, 9));
            end
            step(logic'($urandom_range(0, 99) < 55), 8'($urandom),
                 logic'($urandom_range(0, 99) < 50),
                 logic'($urandom_range(0, 59) == 0),
                 logic'($urandom_range(0, 149) == 0));
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
